// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_gen
//  Description : 640x480@60 VGA raster timing (counters, syncs, bright, ticks)
//                with an internal pixel-enable divider. Optional colour-bar
//                test pattern on test_rgb when VGA_TEST_PATTERN_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int CLK_DIV      = 4,
    parameter int H_TOTAL      = 800,
    parameter int H_SYNC       = 96,
    parameter int H_DISP_START = 144,
    parameter int H_DISP_END   = 784,
    parameter int V_TOTAL      = 525,
    parameter int V_SYNC       = 2,
    parameter int V_DISP_START = 35,
    parameter int V_DISP_END   = 515
) (
    input  logic       clk,
    input  logic       rst,
    output logic       pix_tick,
    output logic [9:0] hCount,
    output logic [9:0] vCount,
    output logic       bright,
    output logic       hSync,
    output logic       vSync,
    output logic       line_tick,
    output logic       frame_tick
`ifdef VGA_TEST_PATTERN_EN
    ,
    output logic [11:0] test_rgb
`endif
);

    localparam int               c_div_w        = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_div_w-1:0] c_div_last   = c_div_w'(CLK_DIV - 1);
    localparam logic [9:0]       c_h_last       = 10'(H_TOTAL - 1);
    localparam logic [9:0]       c_v_last       = 10'(V_TOTAL - 1);
    localparam logic [9:0]       c_h_sync       = 10'(H_SYNC);
    localparam logic [9:0]       c_v_sync       = 10'(V_SYNC);
    localparam logic [9:0]       c_h_disp_start = 10'(H_DISP_START);
    localparam logic [9:0]       c_h_disp_end   = 10'(H_DISP_END);
    localparam logic [9:0]       c_v_disp_start = 10'(V_DISP_START);
    localparam logic [9:0]       c_v_disp_end   = 10'(V_DISP_END);

    logic [c_div_w-1:0] r_div_cnt;
    logic [9:0]         r_h_count;
    logic [9:0]         r_v_count;
    logic               r_bright;
    logic               r_h_sync;
    logic               r_v_sync;
    logic               r_line_tick;
    logic               r_frame_tick;

    logic               w_pix_tick;
    logic               w_h_wrap;
    logic               w_v_wrap;
    logic [9:0]         w_h_next;
    logic [9:0]         w_v_next;
    logic               w_bright_next;

    assign w_pix_tick = (r_div_cnt == c_div_last);
    assign w_h_wrap   = w_pix_tick && (r_h_count == c_h_last);
    assign w_v_wrap   = w_h_wrap && (r_v_count == c_v_last);

    always_comb begin
        w_h_next = r_h_count;
        w_v_next = r_v_count;
        if (w_pix_tick) begin
            w_h_next = w_h_wrap ? 10'd0 : r_h_count + 10'd1;
            if (w_h_wrap) begin
                w_v_next = w_v_wrap ? 10'd0 : r_v_count + 10'd1;
            end
        end
    end

    // Decodes use the next counter values so the registered outputs line up
    // with hCount/vCount in the same cycle.
    assign w_bright_next = (w_h_next >= c_h_disp_start) && (w_h_next < c_h_disp_end) &&
                           (w_v_next >= c_v_disp_start) && (w_v_next < c_v_disp_end);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_cnt    <= '0;
            r_h_count    <= 10'd0;
            r_v_count    <= 10'd0;
            r_bright     <= 1'b0;
            r_h_sync     <= 1'b0;
            r_v_sync     <= 1'b0;
            r_line_tick  <= 1'b0;
            r_frame_tick <= 1'b0;
        end else begin
            r_div_cnt    <= w_pix_tick ? '0 : r_div_cnt + 1'b1;
            r_h_count    <= w_h_next;
            r_v_count    <= w_v_next;
            r_bright     <= w_bright_next;
            r_h_sync     <= ~(w_h_next < c_h_sync);
            r_v_sync     <= ~(w_v_next < c_v_sync);
            r_line_tick  <= w_h_wrap;
            r_frame_tick <= w_v_wrap;
        end
    end

    assign pix_tick   = w_pix_tick;
    assign hCount     = r_h_count;
    assign vCount     = r_v_count;
    assign bright     = r_bright;
    assign hSync      = r_h_sync;
    assign vSync      = r_v_sync;
    assign line_tick  = r_line_tick;
    assign frame_tick = r_frame_tick;

`ifdef VGA_TEST_PATTERN_EN
    localparam logic [9:0] c_bar_w = 10'd80;

    logic [9:0]  w_h_off;
    logic [2:0]  w_bar;
    logic [11:0] w_rgb_next;
    logic [11:0] r_test_rgb;

    assign w_h_off = w_h_next - c_h_disp_start;
    assign w_bar   = 3'(w_h_off / c_bar_w);

    always_comb begin
        w_rgb_next = 12'h000;
        if (w_bright_next) begin
            case (w_bar)
                3'd0:    w_rgb_next = 12'hFFF;
                3'd1:    w_rgb_next = 12'hFF0;
                3'd2:    w_rgb_next = 12'h0FF;
                3'd3:    w_rgb_next = 12'h0F0;
                3'd4:    w_rgb_next = 12'hF0F;
                3'd5:    w_rgb_next = 12'hF00;
                3'd6:    w_rgb_next = 12'h00F;
                default: w_rgb_next = 12'h000;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_test_rgb <= 12'h000;
        end else begin
            r_test_rgb <= w_rgb_next;
        end
    end

    assign test_rgb = r_test_rgb;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_timing_gen
//  Description : Self-checking bench for vga_timing_gen; closed-form raster
//                model checked every cycle plus hand-computed anchor points.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    logic clk;
    logic rst;
    int   k;
    logic started;
    logic phase2;
    int   n_checks;
    int   n_errors;

    logic       a_pix, a_br, a_hs, a_vs, a_lt, a_ft;
    logic [9:0] a_h, a_v;
    logic       b_pix, b_br, b_hs, b_vs, b_lt, b_ft;
    logic [9:0] b_h, b_v;
    logic       c_pix, c_br, c_hs, c_vs, c_lt, c_ft;
    logic [9:0] c_h, c_v;
    logic       d_pix, d_br, d_hs, d_vs, d_lt, d_ft;
    logic [9:0] d_h, d_v;
`ifdef VGA_TEST_PATTERN_EN
    logic [11:0] a_rgb, b_rgb, c_rgb, d_rgb;
`endif

    // A: all defaults
    vga_timing_gen u_a (
        .clk(clk), .rst(rst), .pix_tick(a_pix), .hCount(a_h), .vCount(a_v),
        .bright(a_br), .hSync(a_hs), .vSync(a_vs), .line_tick(a_lt), .frame_tick(a_ft)
`ifdef VGA_TEST_PATTERN_EN
        , .test_rgb(a_rgb)
`endif
    );

    // B: default raster geometry at 2 clks per pixel
    vga_timing_gen #(.CLK_DIV(2)) u_b (
        .clk(clk), .rst(rst), .pix_tick(b_pix), .hCount(b_h), .vCount(b_v),
        .bright(b_br), .hSync(b_hs), .vSync(b_vs), .line_tick(b_lt), .frame_tick(b_ft)
`ifdef VGA_TEST_PATTERN_EN
        , .test_rgb(b_rgb)
`endif
    );

    // C: tiny raster
    vga_timing_gen #(
        .CLK_DIV(2), .H_TOTAL(10), .H_SYNC(2), .H_DISP_START(3), .H_DISP_END(8),
        .V_TOTAL(4), .V_SYNC(1), .V_DISP_START(1), .V_DISP_END(3)
    ) u_c (
        .clk(clk), .rst(rst), .pix_tick(c_pix), .hCount(c_h), .vCount(c_v),
        .bright(c_br), .hSync(c_hs), .vSync(c_vs), .line_tick(c_lt), .frame_tick(c_ft)
`ifdef VGA_TEST_PATTERN_EN
        , .test_rgb(c_rgb)
`endif
    );

    // D: short lines, default vertical timing
    vga_timing_gen #(
        .CLK_DIV(2), .H_TOTAL(16), .H_SYNC(2), .H_DISP_START(3), .H_DISP_END(13)
    ) u_d (
        .clk(clk), .rst(rst), .pix_tick(d_pix), .hCount(d_h), .vCount(d_v),
        .bright(d_br), .hSync(d_hs), .vSync(d_vs), .line_tick(d_lt), .frame_tick(d_ft)
`ifdef VGA_TEST_PATTERN_EN
        , .test_rgb(d_rgb)
`endif
    );

    always #5 clk = ~clk;

    // k = clk edges since the last edge that sampled rst high
    always @(posedge clk) begin
        if (rst) begin
            k       <= 0;
            started <= 1'b1;
        end else begin
            k <= k + 1;
        end
    end

    // Raster position follows directly from elapsed pixel periods.
    function automatic logic [25:0] model(input int kk, input int dv, input int ht,
                                          input int hsw, input int hds, input int hde,
                                          input int vt, input int vsw, input int vds,
                                          input int vde);
        int         n, h, v;
        logic       pix, adv, br, hs, vs, lt, ft;
        logic [9:0] h10, v10;
        n   = kk / dv;
        h   = n % ht;
        v   = (n / ht) % vt;
        pix = (kk % dv) == (dv - 1);
        adv = (kk > 0) && ((kk % dv) == 0);
        lt  = adv && (h == 0);
        ft  = lt && (v == 0);
        hs  = (h >= hsw);
        vs  = (v >= vsw);
        br  = (h >= hds) && (h < hde) && (v >= vds) && (v < vde);
        h10 = h[9:0];
        v10 = v[9:0];
        return {pix, h10, v10, br, hs, vs, lt, ft};
    endfunction

    function automatic logic [11:0] model_rgb(input logic [25:0] m, input int hds);
        int bar;
        if (!m[4]) return 12'h000;
        bar = (int'(m[24:15]) - hds) / 80;
        case (bar)
            0: return 12'hFFF;
            1: return 12'hFF0;
            2: return 12'h0FF;
            3: return 12'h0F0;
            4: return 12'hF0F;
            5: return 12'hF00;
            6: return 12'h00F;
            default: return 12'h000;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s k=%0d actual=%h required=%h", name, k, act, exp);
        end
    endtask

    logic [25:0] m_a, m_b, m_c, m_d;

    always @(negedge clk) begin
        if (started) begin
            m_a = model(k, 4, 800, 96, 144, 784, 525, 2, 35, 515);
            m_b = model(k, 2, 800, 96, 144, 784, 525, 2, 35, 515);
            m_c = model(k, 2, 10, 2, 3, 8, 4, 1, 1, 3);
            m_d = model(k, 2, 16, 2, 3, 13, 525, 2, 35, 515);
            check("A_cycle", 32'({a_pix, a_h, a_v, a_br, a_hs, a_vs, a_lt, a_ft}), 32'(m_a));
            check("B_cycle", 32'({b_pix, b_h, b_v, b_br, b_hs, b_vs, b_lt, b_ft}), 32'(m_b));
            check("C_cycle", 32'({c_pix, c_h, c_v, c_br, c_hs, c_vs, c_lt, c_ft}), 32'(m_c));
            check("D_cycle", 32'({d_pix, d_h, d_v, d_br, d_hs, d_vs, d_lt, d_ft}), 32'(m_d));
`ifdef VGA_TEST_PATTERN_EN
            check("A_rgb", 32'(a_rgb), 32'(model_rgb(m_a, 144)));
            check("B_rgb", 32'(b_rgb), 32'(model_rgb(m_b, 144)));
`endif
            if (k == 0) begin
                check("A_reset_zero", 32'({a_pix, a_h, a_v, a_br, a_hs, a_vs, a_lt, a_ft}), 32'd0);
                check("C_reset_zero", 32'({c_pix, c_h, c_v, c_br, c_hs, c_vs, c_lt, c_ft}), 32'd0);
            end
            if (phase2) begin
                case (k)
                    3:     check("A_k3_pix_h",   32'({a_pix, a_h}), {21'd0, 1'b1, 10'd0});
                    4:     check("A_k4_pix_h",   32'({a_pix, a_h}), {21'd0, 1'b0, 10'd1});
                    7:     check("A_k7_pix",     32'(a_pix), 32'd1);
                    26:    check("C_br_3_1",     32'(c_br), 32'd1);
                    36:    check("C_br_8_1",     32'(c_br), 32'd0);
                    66:    check("C_br_3_3",     32'(c_br), 32'd0);
                    79:    check("C_ft_k79",     32'(c_ft), 32'd0);
                    80:    check("C_ft_k80",     32'({c_ft, c_h, c_v}), {11'd0, 1'b1, 20'd0});
                    160:   check("C_ft_k160",    32'(c_ft), 32'd1);
                    383:   check("A_hs_95",      32'({a_h, a_hs}), {21'd0, 10'd95, 1'b0});
                    384:   check("A_hs_96",      32'({a_h, a_hs}), {21'd0, 10'd96, 1'b1});
                    1094:  check("D_br_3_34",    32'(d_br), 32'd0);
                    1126:  check("D_br_3_35",    32'(d_br), 32'd1);
                    1620:  check("B_vs_line1",   32'(b_vs), 32'd0);
                    3200:  check("A_lt_wrap",    32'({a_lt, a_h, a_v}), {11'd0, 1'b1, 10'd0, 10'd1});
                    3201:  check("A_lt_drop",    32'(a_lt), 32'd0);
                    3220:  check("B_vs_line2",   32'(b_vs), 32'd1);
                    16454: check("D_br_3_514",   32'(d_br), 32'd1);
                    16486: check("D_br_3_515",   32'(d_br), 32'd0);
                    16798: check("D_last_pix",   32'({d_h, d_v, d_ft}), {11'd0, 10'd15, 10'd524, 1'b0});
                    16800: check("D_ft_first",   32'({d_ft, d_h, d_v}), {11'd0, 1'b1, 20'd0});
                    17599: check("B_eol_10",     32'({b_lt, b_h, b_v}), {11'd0, 1'b0, 10'd799, 10'd10});
                    17600: check("B_lt_v11",     32'({b_lt, b_h, b_v}), {11'd0, 1'b1, 10'd0, 10'd11});
                    33600: check("D_ft_second",  32'(d_ft), 32'd1);
                    54688: check("B_br_144_34",  32'(b_br), 32'd0);
`ifdef VGA_TEST_PATTERN_EN
                    56200: check("B_rgb_100_35", 32'({b_br, b_rgb}), {19'd0, 1'b0, 12'h000});
                    56448: check("B_rgb_224_35", 32'(b_rgb), 32'h0FF0);
`endif
                    56286: check("B_br_143_35",  32'({b_h, b_br}), {21'd0, 10'd143, 1'b0});
                    56288: check("B_br_144_35",  32'({b_h, b_br}), {21'd0, 10'd144, 1'b1});
                    57566: check("B_br_783_35",  32'({b_h, b_br}), {21'd0, 10'd783, 1'b1});
                    57568: check("B_br_784_35",  32'({b_h, b_br}), {21'd0, 10'd784, 1'b0});
                    default: ;
                endcase
            end
        end
    end

    initial begin
        clk      = 1'b0;
        rst      = 1'b1;
        k        = 0;
        started  = 1'b0;
        phase2   = 1'b0;
        n_checks = 0;
        n_errors = 0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        repeat (5000) @(posedge clk);
        // reset again mid-line / mid-frame on every instance
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        phase2 = 1'b1;
        repeat (57700) @(posedge clk);
        #2;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
